apb_uart_bus_arbiter: RTL
=========================

Name: apb_uart_bus_arbiter

Overview:
- Two-port APB master front end that shares the single APB bus between two requesters: port 0 (host/config sequencer) and port 1 (UART service engine).
- Round-robin arbitration, one outstanding transfer at a time.
- Drives the APB setup/access phases and decodes the address into the two slave selects.
- Returns read data and error per requester, with a per-transfer PREADY timeout.

Parameters:
- ADDR_W, 5, APB address width; bit ADDR_W-1 selects the slave.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles waiting for i_pready before abort (legal range 2..255).

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_m0_valid  in  1  port 0 request valid, held until o_m0_ready
- i_m0_write  in  1  port 0: 1 = write, 0 = read
- i_m0_addr  in  ADDR_W  port 0 address
- i_m0_wdata  in  DATA_W  port 0 write data
- o_m0_ready  out  1  port 0 request accepted (1-cycle pulse)
- o_m0_done  out  1  port 0 transfer complete (1-cycle pulse)
- o_m0_rdata  out  DATA_W  port 0 read data, valid with o_m0_done
- o_m0_err  out  1  port 0 error (PSLVERR or timeout), valid with o_m0_done
- i_m1_valid, i_m1_write, i_m1_addr, i_m1_wdata, o_m1_ready, o_m1_done, o_m1_rdata, o_m1_err: same as port 0, for port 1
- o_psel  out  2  APB slave selects, one-hot or zero
- o_penable  out  1  APB enable
- o_pwrite  out  1  APB write
- o_paddr  out  ADDR_W  APB address
- o_pwdata  out  DATA_W  APB write data
- i_prdata  in  DATA_W  APB read data
- i_pready  in  1  APB ready
- i_pslverr  in  1  APB slave error

Behaviour:
- Reset (i_rst = 1 at a clock edge):
  - FSM returns to IDLE.
  - All outputs go to 0.
  - Timeout counter cleared; round-robin pointer set so port 0 wins the first contention.
- Reset mid-transfer: psel/penable drop at that edge; no done pulse is issued; the latched command is discarded.
- FSM states and transitions:
  - IDLE:
    - If any valid: grant the winner, pulse o_mX_ready for 1 cycle, latch write/addr/wdata, go to SETUP.
    - One valid: that port wins.
    - Both valid: the port not granted last wins; pointer updates on every grant.
  - SETUP (1 cycle):
    - o_psel[o_paddr[ADDR_W-1]] = 1, o_penable = 0, go to ACCESS.
    - o_paddr, o_pwrite, o_pwdata are driven from the latch and stay stable through ACCESS.
  - ACCESS:
    - o_penable = 1, psel held; counter increments each cycle.
    - i_pready = 1: capture i_prdata (reads only; writes return 0), err = i_pslverr, go to RESP.
    - Counter reaches TIMEOUT without i_pready: err = 1, rdata = 0, go to RESP.
  - RESP (1 cycle):
    - o_psel = 0, o_penable = 0.
    - Granted port gets o_mX_done = 1 with rdata/err; counter cleared; go to IDLE.
- Latency and throughput:
  - Ready pulse in cycle N; SETUP N+1; ACCESS N+2.
  - With zero-wait i_pready, done is asserted in N+3.
  - Minimum 4 cycles per transfer: a back-to-back grant occurs in the IDLE cycle following RESP.
- Output hold rules:
  - o_mX_rdata/o_mX_err hold their values until that port's next done.
  - Done and ready pulses never go to the non-granted port.
- i_pslverr is sampled only together with i_pready = 1; i_prdata is ignored on writes.
- A requester changing addr/wdata after its ready pulse has no effect on the transfer.
- Timeout boundary: with TIMEOUT = 16, i_pready arriving in the 16th ACCESS cycle completes normally; absent through 16 ACCESS cycles, the transfer aborts.
- No other requester is granted until RESP completes; requests are never lost or reordered within a port.

Test Plan:
- Port 0 write addr 0x02 data 0xA5A5_0001, i_pready tied 1 -> o_psel = 01 for 2 cycles, penable 1 in the second, pwrite = 1, pwdata = 0xA5A5_0001; o_m0_done 3 cycles after o_m0_ready, err 0.
- Port 1 read addr 0x11, i_pready after 3 wait cycles with prdata 0x0000_00C3 -> o_psel = 10 held for 5 cycles; o_m1_rdata = 0xC3, err 0.
- Both ports valid continuously for 4 transfers -> grant order 0,1,0,1; each done pulse goes only to its port; 4 cycles per transfer.
- Port 0 read, i_pready never asserted -> abort after 16 ACCESS cycles; o_m0_err = 1, o_m0_rdata = 0; next request is serviced normally.
- Port 1 write, i_pready = 1 with i_pslverr = 1 -> o_m1_err = 1 on done; i_pslverr = 1 while i_pready = 0 -> ignored.
- Reset asserted in the second ACCESS cycle -> psel/penable = 0 at the next edge; no done; after release, simultaneous requests grant port 0 first.

Source files
------------

// File: rtl/apb_uart_bus_arbiter.sv
// apb_uart_bus_arbiter: round-robin two-port APB master front end with PREADY timeout
module apb_uart_bus_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_m0_valid,
  input  logic              i_m0_write,
  input  logic [ADDR_W-1:0] i_m0_addr,
  input  logic [DATA_W-1:0] i_m0_wdata,
  output logic              o_m0_ready,
  output logic              o_m0_done,
  output logic [DATA_W-1:0] o_m0_rdata,
  output logic              o_m0_err,
  input  logic              i_m1_valid,
  input  logic              i_m1_write,
  input  logic [ADDR_W-1:0] i_m1_addr,
  input  logic [DATA_W-1:0] i_m1_wdata,
  output logic              o_m1_ready,
  output logic              o_m1_done,
  output logic [DATA_W-1:0] o_m1_rdata,
  output logic              o_m1_err,
  output logic [1:0]        o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);
  localparam logic [1:0] IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3;
  logic [1:0] state;
  logic gnt, last, req, win, take, tmo, fin;
  logic [7:0] cnt;
  logic [DATA_W-1:0] rd_val;
  logic err_val;
  assign req = i_m0_valid | i_m1_valid;
  // with both requesting, the port not granted last wins
  assign win = (i_m0_valid & i_m1_valid) ? ~last : i_m1_valid;
  assign take = (state == IDLE) & req & ~i_rst;
  assign o_m0_ready = take & ~win;
  assign o_m1_ready = take & win;
  assign o_psel = (state == SETUP || state == ACCESS) ? (o_paddr[ADDR_W-1] ? 2'b10 : 2'b01) : 2'b00;
  assign o_penable = state == ACCESS;
  assign o_m0_done = (state == RESP) & ~gnt;
  assign o_m1_done = (state == RESP) & gnt;
  assign tmo = cnt == 8'(TIMEOUT - 1);
  assign fin = i_pready | tmo;
  assign rd_val = (i_pready & ~o_pwrite) ? i_prdata : '0;
  assign err_val = i_pready ? i_pslverr : 1'b1;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
      o_pwrite <= 1'b0;
      o_paddr <= '0;
      o_pwdata <= '0;
      o_m0_rdata <= '0;
      o_m0_err <= 1'b0;
      o_m1_rdata <= '0;
      o_m1_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          gnt <= win;
          last <= win;
          o_pwrite <= win ? i_m1_write : i_m0_write;
          o_paddr <= win ? i_m1_addr : i_m0_addr;
          o_pwdata <= win ? i_m1_wdata : i_m0_wdata;
          state <= SETUP;
        end
        SETUP: begin
          cnt <= '0;
          state <= ACCESS;
        end
        ACCESS: if (fin) begin
          state <= RESP;
          if (gnt) begin
            o_m1_rdata <= rd_val;
            o_m1_err <= err_val;
          end else begin
            o_m0_rdata <= rd_val;
            o_m0_err <= err_val;
          end
        end else cnt <= cnt + 8'd1;
        default: begin
          cnt <= '0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
